// File: rtl/spawn_pos_sched.sv
// Random spawn-position scheduler: two LFSRs sampled by rejection into the visible
// area, round-robin arbitration between two requesters, bounded retries with fallback.
module spawn_pos_sched #(
    parameter int unsigned X_MAX     = 640,
    parameter int unsigned Y_MAX     = 480,
    parameter int unsigned MAX_TRIES = 8,
    parameter logic [9:0]  SEED_X    = 10'h2A5,
    parameter logic [8:0]  SEED_Y    = 9'h1C3
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       seed_ld,
    input  logic [9:0] seed_x,
    input  logic [8:0] seed_y,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       pos_valid,
    output logic [9:0] pos_x,
    output logic [8:0] pos_y,
    output logic       fallback,
    output logic       busy
);

    localparam int unsigned TW = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);
    localparam logic [10:0] XLIM = 11'(X_MAX);
    localparam logic [9:0]  YLIM = 10'(Y_MAX);

    typedef enum logic [1:0] {IDLE, SAMPLE, OUT} state_t;

    state_t        state_q, state_d;
    logic          grantee_q, grantee_d;
    logic          last_q, last_d;
    logic [TW-1:0] tries_q, tries_d;
    logic [9:0]    x_q, x_d;
    logic [8:0]    y_q, y_d;
    logic [9:0]    pos_x_q, pos_x_d;
    logic [8:0]    pos_y_q, pos_y_d;
    logic          fb_q, fb_d;
    logic          x_ok, y_ok;

    assign x_ok = {1'b0, x_q} < XLIM;
    assign y_ok = {1'b0, y_q} < YLIM;

    always_comb begin
        if (seed_ld) begin
            x_d = (seed_x == '0) ? 10'd1 : seed_x;
            y_d = (seed_y == '0) ? 9'd1 : seed_y;
        end else begin
            x_d = {x_q[3] ^ x_q[0], x_q[9:1]};
            y_d = {y_q[4] ^ y_q[0], y_q[8:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            grantee_q <= 1'b0;
            last_q    <= 1'b1;
            tries_q   <= '0;
            x_q       <= SEED_X;
            y_q       <= SEED_Y;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            fb_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            grantee_q <= grantee_d;
            last_q    <= last_d;
            tries_q   <= tries_d;
            x_q       <= x_d;
            y_q       <= y_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            fb_q      <= fb_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grantee_d = grantee_q;
        last_d    = last_q;
        tries_d   = tries_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        fb_d      = fb_q;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    // On a tie the requester not served last wins.
                    grantee_d = (req == 2'b11) ? ~last_q : req[1];
                    tries_d   = '0;
                    state_d   = SAMPLE;
                end
            end
            SAMPLE: begin
                if (!req[grantee_q]) begin
                    state_d = IDLE;
                end else if (x_ok && y_ok) begin
                    pos_x_d = x_q;
                    pos_y_d = y_q;
                    fb_d    = 1'b0;
                    state_d = OUT;
                end else if (tries_q == LAST_TRY) begin
                    // Single subtraction suffices: bounds cover at least half the LFSR range.
                    pos_x_d = x_ok ? x_q : x_q - XLIM[9:0];
                    pos_y_d = y_ok ? y_q : y_q - YLIM[8:0];
                    fb_d    = 1'b1;
                    state_d = OUT;
                end else begin
                    tries_d = tries_q + 1'b1;
                end
            end
            OUT: begin
                last_d  = grantee_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pos_valid = (state_q == OUT);
        gnt       = '0;
        if (state_q == OUT) begin
            gnt = grantee_q ? 2'b10 : 2'b01;
        end
        fallback  = (state_q == OUT) && fb_q;
        busy      = (state_q != IDLE);
        pos_x     = pos_x_q;
        pos_y     = pos_y_q;
    end

endmodule

// File: doc/spawn_pos_sched.md
# spawn_pos_sched

Random-position scheduler for on-screen object spawning. Owns a 10-bit x-axis LFSR and a 9-bit y-axis LFSR. Arbitrates spawn requests from two requesters round-robin. Uses rejection sampling on the LFSR state to return a coordinate inside the 640x480 visible area, with a bounded retry count and a deterministic fallback. Sits between the game-logic spawners (enemy, pickup) and the object-position registers.

## Interface

Parameters:
- X_MAX, 640: exclusive x bound.
- Y_MAX, 480: exclusive y bound.
- MAX_TRIES, 8: samples evaluated before fallback (>=1).
- SEED_X, 10'h2A5: x LFSR value after clr.
- SEED_Y, 9'h1C3: y LFSR value after clr.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset; synchronous, active-high.
- seed_ld  in  1  load seed_x/seed_y into LFSRs this cycle.
- seed_x  in  10  x seed.
- seed_y  in  9  y seed.
- req  in  2  level spawn requests, bit i = requester i; held until gnt[i].
- gnt  out  2  one-hot grant, high only in the pos_valid cycle.
- pos_valid  out  1  one-cycle pulse, pos_x/pos_y valid.
- pos_x  out  10  spawn x, < X_MAX.
- pos_y  out  9  spawn y, < Y_MAX.
- fallback  out  1  qualifies pos_valid; the position came from the fallback path.
- busy  out  1  FSM not in IDLE.

## Operation

- LFSR step, every cycle without seed_ld or clr:
  - x: x <= {x[3]^x[0], x[9:1]}
  - y: y <= {y[4]^y[0], y[8:1]}
- seed_ld:
  - Loads the seeds instead of stepping.
  - A zero seed field is replaced by 1 (all-zero lock avoided).
  - Affects neither FSM nor tries.
- clr:
  - LFSRs load SEED_X/SEED_Y; state IDLE; tries 0.
  - Round-robin pointer set so requester 0 wins a tie.
  - All outputs 0.
- IDLE:
  - If req != 0, pick the grantee:
    - Only one bit set: that requester.
    - Both set: the requester not served last.
  - Latch grantee, tries <= 0, go SAMPLE.
- SAMPLE, evaluates current LFSR values (x, y):
  - Grantee's req low: abort to IDLE. No pos_valid, pointer unchanged.
  - Else if x < X_MAX and y < Y_MAX: register pos = (x, y), fallback 0, go OUT.
  - Else if tries == MAX_TRIES-1: register fallback position, fallback 1, go OUT.
    - pos_x = x >= X_MAX ? x - X_MAX : x
    - pos_y = y >= Y_MAX ? y - Y_MAX : y
    - Holds because X_MAX/Y_MAX >= half of the LFSR range.
  - Else tries++, stay. The LFSRs have advanced, so the next cycle sees a new sample.
- OUT:
  - pos_valid = 1, gnt[grantee] = 1, fallback as registered.
  - Update pointer to grantee; go IDLE.
  - Requester may drop req the following cycle.
- pos_x/pos_y hold their last value outside OUT; only the pos_valid cycle is meaningful.
- busy = (state != IDLE).
- Comparisons unsigned; subtraction width equals field width, no wrap possible.

## Timing

- req seen in IDLE at cycle t:
  - SAMPLE at t+1.
  - Earliest pos_valid/gnt at t+2.
  - Latest at t+1+MAX_TRIES.
- Back-to-back: minimum 3 cycles between pos_valid pulses, because OUT returns through IDLE.
- seed_ld in the same cycle as an IDLE grant: the t+1 SAMPLE evaluates exactly the loaded seed.
- seed_ld during SAMPLE: that cycle evaluates the pre-load values; the loaded values are seen next cycle.
- clr wins over seed_ld and over all FSM activity. clr mid-SAMPLE or in OUT: no pos_valid on the following cycle.
- All outputs registered; no combinational path from req to gnt.

## Test plan

- Reset defaults: after clr, next cycle all outputs 0, busy 0.
  - Then req=2'b11 -> gnt=2'b01 first.
  - Both held -> gnt=2'b10, then 2'b01 (alternation).
- Direct accept: cycle 0 seed_ld (x=5, y=7), req=2'b01.
  - Cycle 1 busy=1.
  - Cycle 2 pos_valid=1, gnt=01, pos=(5,7), fallback=0.
- Rejection: cycle 0 seed_ld (x=1023, y=7), req=2'b01.
  - Cycle 1 rejects; LFSRs step to (511, 259).
  - Cycle 3 pos_valid, pos=(511,259), fallback=0.
- Fallback: MAX_TRIES=1; cycle 0 seed_ld (x=1023, y=7), req=2'b10.
  - Cycle 2 pos_valid, gnt=10, pos=(383,7), fallback=1.
- Zero seed / abort:
  - seed_ld (0,0) with req=01 -> pos=(1,1).
  - Separately: seed (1023,7), req0 dropped in cycle 1 -> IDLE at cycle 2, no pos_valid.
  - Next tie still grants requester 0.
- clr mid-SAMPLE: assert clr in cycle 1 of the rejection scenario.
  - Cycle 2: busy=0, no pos_valid.
  - LFSRs = (SEED_X, SEED_Y), verified by a subsequent accept path.
